memoria_dados_respondedor: RTL and testbench

- Data-memory responder: the target end of the processor's load/store interface.
- Replaces the zero-latency combinational data array with a handshaked slave that has a programmable wait-state count.
- Accepts one byte, half-word or word request at a time, applies little-endian lane masking and sign/zero extension, and returns a held response with an error flag.
- Sits between the processor's load/store stage and a PROFUNDIDADE-word storage array.

---
 rtl/memoria_dados_respondedor.sv | 176 +++++++++++++++++
 tb/tb_memoria_dados_respondedor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/memoria_dados_respondedor.sv
// Data-memory responder: target end of the processor load/store interface.
// Accepts one byte/half/word request at a time, waits LATENCIA cycles, then
// commits the access against a PROFUNDIDADE-word little-endian array and
// holds the response until the initiator accepts it.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_valido / req_pronto   request handshake
//   req_escreve               1 = store, 0 = load
//   req_tamanho               00 byte, 01 half, 10 word, 11 illegal
//   req_sem_sinal             loads: 1 = zero-extend, 0 = sign-extend
//   req_endereco, req_dado    byte address, right-aligned store data
//   resp_valido / resp_aceito response handshake
//   resp_dado, resp_erro      extended load data (0 on store/error), error flag
//
// state    | meaning
// OCIOSO   | idle, ready to accept a request
// ESPERA   | request latched, counting down wait states
// RESPOSTA | response held until resp_aceito
module memoria_dados_respondedor #(
    parameter int PROFUNDIDADE = 64,
    parameter int LATENCIA     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valido,
    output logic        req_pronto,
    input  logic        req_escreve,
    input  logic [1:0]  req_tamanho,
    input  logic        req_sem_sinal,
    input  logic [31:0] req_endereco,
    input  logic [31:0] req_dado,
    output logic        resp_valido,
    input  logic        resp_aceito,
    output logic [31:0] resp_dado,
    output logic        resp_erro
);

    localparam int          IW     = $clog2(PROFUNDIDADE);
    localparam logic [31:0] PROF_W = 32'(PROFUNDIDADE);

    typedef enum logic [1:0] {OCIOSO, ESPERA, RESPOSTA} estado_t;

    estado_t     estado, prox_estado;
    logic [3:0]  contador, prox_contador;
    logic        aceita, commit;

    logic        escreve_l;
    logic [1:0]  tamanho_l;
    logic        sem_sinal_l;
    logic [31:0] endereco_l;
    logic [31:0] dado_l;

    // Zero at time 0; reset deliberately leaves the contents alone.
    logic [31:0] mem [0:PROFUNDIDADE-1] = '{default: '0};

    logic [IW-1:0] indice;
    logic [31:0]   palavra;
    logic          erro;
    logic [7:0]    byte_sel;
    logic [15:0]   meia_sel;
    logic [31:0]   dado_lido;
    logic [3:0]    lanes;
    logic [31:0]   dado_esc;

    assign req_pronto  = (estado == OCIOSO);
    assign resp_valido = (estado == RESPOSTA);

    always_comb begin
        prox_estado   = estado;
        prox_contador = contador;
        aceita        = 1'b0;
        commit        = 1'b0;
        case (estado)
            OCIOSO: begin
                if (req_valido) begin
                    aceita        = 1'b1;
                    prox_estado   = ESPERA;
                    prox_contador = 4'(LATENCIA);
                end
            end
            ESPERA: begin
                if (contador == 4'd0) begin
                    commit      = 1'b1;
                    prox_estado = RESPOSTA;
                end else begin
                    prox_contador = contador - 4'd1;
                end
            end
            RESPOSTA: begin
                if (resp_aceito) prox_estado = OCIOSO;
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    // Access decode works only on the latched request, so input changes
    // after acceptance cannot affect the commit.
    always_comb begin
        indice  = endereco_l[IW+1:2];
        palavra = mem[indice];
        erro    = (tamanho_l == 2'b11)
                | ((tamanho_l == 2'b01) & endereco_l[0])
                | ((tamanho_l == 2'b10) & (endereco_l[1:0] != 2'b00))
                | ({2'b00, endereco_l[31:2]} >= PROF_W);

        case (endereco_l[1:0])
            2'd0:    byte_sel = palavra[7:0];
            2'd1:    byte_sel = palavra[15:8];
            2'd2:    byte_sel = palavra[23:16];
            default: byte_sel = palavra[31:24];
        endcase
        meia_sel = endereco_l[1] ? palavra[31:16] : palavra[15:0];

        case (tamanho_l)
            2'b00:   dado_lido = sem_sinal_l ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   dado_lido = sem_sinal_l ? {16'd0, meia_sel} : {{16{meia_sel[15]}}, meia_sel};
            default: dado_lido = palavra;
        endcase

        case (tamanho_l)
            2'b00: begin
                lanes    = 4'b0001 << endereco_l[1:0];
                dado_esc = {4{dado_l[7:0]}};
            end
            2'b01: begin
                lanes    = endereco_l[1] ? 4'b1100 : 4'b0011;
                dado_esc = {2{dado_l[15:0]}};
            end
            default: begin
                lanes    = 4'b1111;
                dado_esc = dado_l;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado      <= OCIOSO;
            contador    <= 4'd0;
            escreve_l   <= 1'b0;
            tamanho_l   <= 2'b00;
            sem_sinal_l <= 1'b0;
            endereco_l  <= 32'd0;
            dado_l      <= 32'd0;
            resp_dado   <= 32'd0;
            resp_erro   <= 1'b0;
        end else begin
            estado   <= prox_estado;
            contador <= prox_contador;
            if (aceita) begin
                escreve_l   <= req_escreve;
                tamanho_l   <= req_tamanho;
                sem_sinal_l <= req_sem_sinal;
                endereco_l  <= req_endereco;
                dado_l      <= req_dado;
            end
            if (commit) begin
                resp_dado <= (erro || escreve_l) ? 32'd0 : dado_lido;
                resp_erro <= erro;
            end else if ((estado == RESPOSTA) && resp_aceito) begin
                resp_dado <= 32'd0;
                resp_erro <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && escreve_l && !erro) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i]) mem[indice][8*i +: 8] <= dado_esc[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_memoria_dados_respondedor.sv
module tb_memoria_dados_respondedor;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valido, req_escreve, req_sem_sinal, resp_aceito;
    logic [1:0]  req_tamanho;
    logic [31:0] req_endereco, req_dado;

    logic        req_pronto, resp_valido, resp_erro;
    logic [31:0] resp_dado;
    logic        req_pronto_z, resp_valido_z, resp_erro_z;
    logic [31:0] resp_dado_z;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memoria_dados_respondedor #(.PROFUNDIDADE(64), .LATENCIA(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valido(req_valido), .req_pronto(req_pronto),
        .req_escreve(req_escreve), .req_tamanho(req_tamanho),
        .req_sem_sinal(req_sem_sinal), .req_endereco(req_endereco),
        .req_dado(req_dado),
        .resp_valido(resp_valido), .resp_aceito(resp_aceito),
        .resp_dado(resp_dado), .resp_erro(resp_erro)
    );

    // Zero-latency copy sharing the same stimulus.
    memoria_dados_respondedor #(.PROFUNDIDADE(64), .LATENCIA(0)) u_dut_z (
        .clk(clk), .rst(rst),
        .req_valido(req_valido), .req_pronto(req_pronto_z),
        .req_escreve(req_escreve), .req_tamanho(req_tamanho),
        .req_sem_sinal(req_sem_sinal), .req_endereco(req_endereco),
        .req_dado(req_dado),
        .resp_valido(resp_valido_z), .resp_aceito(resp_aceito),
        .resp_dado(resp_dado_z), .resp_erro(resp_erro_z)
    );

    // One complete transaction on both DUTs; latency is counted in edges
    // after the acceptance edge until resp_valido is seen high.
    task automatic xact(input logic esc, input logic [1:0] tam, input logic ss,
                        input logic [31:0] addr, input logic [31:0] dado,
                        output logic [31:0] d, output logic e,
                        output int lat, output int lat_z);
        @(negedge clk);
        req_escreve   = esc;
        req_tamanho   = tam;
        req_sem_sinal = ss;
        req_endereco  = addr;
        req_dado      = dado;
        req_valido    = 1'b1;
        @(posedge clk);
        #1;
        req_valido    = 1'b0;
        req_dado      = ~dado;
        req_endereco  = addr ^ 32'h4;
        req_escreve   = ~esc;
        req_sem_sinal = ~ss;
        lat   = -1;
        lat_z = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (resp_valido_z && lat_z < 0) lat_z = n;
            if (resp_valido && lat < 0) lat = n;
            if (lat >= 0) break;
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL xact_timeout: resp_valido never rose for addr %h", addr);
        end
        d = resp_dado;
        e = resp_erro;
        @(negedge clk);
        resp_aceito = 1'b1;
        @(posedge clk);
        #1;
        resp_aceito = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (req_pronto !== 1'b1) begin failures++; $display("FAIL reset_pronto: got %b want 1", req_pronto); end
        checks++; if (resp_valido !== 1'b0) begin failures++; $display("FAIL reset_valido: got %b want 0", resp_valido); end
        checks++; if (resp_dado !== 32'h0) begin failures++; $display("FAIL reset_dado: got %h want 0", resp_dado); end
        checks++; if (resp_erro !== 1'b0) begin failures++; $display("FAIL reset_erro: got %b want 0", resp_erro); end
    endtask

    task automatic test_word();
        logic [31:0] d; logic e; int lat, lat_z;
        xact(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, d, e, lat, lat_z);
        checks++; if (lat !== 3) begin failures++; $display("FAIL word_store_lat: got %0d want 3", lat); end
        checks++; if (lat_z !== 1) begin failures++; $display("FAIL word_store_lat0: got %0d want 1", lat_z); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL word_store_erro: got %b want 0", e); end
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL word_store_dado: got %h want 0", d); end
        xact(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, d, e, lat, lat_z);
        checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL word_load: got %h want deadbeef", d); end
        checks++; if (lat_z !== 1) begin failures++; $display("FAIL word_load_lat0: got %0d want 1", lat_z); end
    endtask

    task automatic test_half();
        logic [31:0] d; logic e; int lat, lat_z;
        xact(1'b1, 2'b01, 1'b0, 32'h12, 32'h55558001, d, e, lat, lat_z);
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL half_store_erro: got %b want 0", e); end
        xact(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, d, e, lat, lat_z);
        checks++; if (d !== 32'hFFFF8001) begin failures++; $display("FAIL half_load_signed: got %h want ffff8001", d); end
        xact(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, d, e, lat, lat_z);
        checks++; if (d !== 32'h00008001) begin failures++; $display("FAIL half_load_unsigned: got %h want 00008001", d); end
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, d, e, lat, lat_z);
        checks++; if (d !== 32'h80010000) begin failures++; $display("FAIL half_word_view: got %h want 80010000", d); end
    endtask

    task automatic test_byte();
        logic [31:0] d; logic e; int lat, lat_z;
        xact(1'b1, 2'b00, 1'b0, 32'h20, 32'hAAAAAA11, d, e, lat, lat_z);
        xact(1'b1, 2'b00, 1'b0, 32'h21, 32'hBBBBBB22, d, e, lat, lat_z);
        xact(1'b1, 2'b00, 1'b0, 32'h22, 32'hCCCCCC33, d, e, lat, lat_z);
        xact(1'b1, 2'b00, 1'b0, 32'h23, 32'hDDDDDD44, d, e, lat, lat_z);
        xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, d, e, lat, lat_z);
        checks++; if (d !== 32'h44332211) begin failures++; $display("FAIL byte_word_view: got %h want 44332211", d); end
        xact(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, d, e, lat, lat_z);
        checks++; if (d !== 32'h00000033) begin failures++; $display("FAIL byte_load_lane2: got %h want 00000033", d); end
        xact(1'b1, 2'b00, 1'b0, 32'h25, 32'h00000080, d, e, lat, lat_z);
        xact(1'b0, 2'b00, 1'b0, 32'h25, 32'h0, d, e, lat, lat_z);
        checks++; if (d !== 32'hFFFFFF80) begin failures++; $display("FAIL byte_load_signed: got %h want ffffff80", d); end
        xact(1'b0, 2'b00, 1'b1, 32'h25, 32'h0, d, e, lat, lat_z);
        checks++; if (d !== 32'h00000080) begin failures++; $display("FAIL byte_load_unsigned: got %h want 00000080", d); end
        xact(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, d, e, lat, lat_z);
        checks++; if (d !== 32'h00008000) begin failures++; $display("FAIL byte_word_view2: got %h want 00008000", d); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e; int lat, lat_z;
        xact(1'b1, 2'b10, 1'b0, 32'h00, 32'hCAFEF00D, d, e, lat, lat_z);
        xact(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, d, e, lat, lat_z);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL err_half_misaligned: got erro=%b dado=%h want 1/0", e, d); end
        xact(1'b1, 2'b10, 1'b0, 32'h06, 32'hA5A5A5A5, d, e, lat, lat_z);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL err_word_misaligned: got erro=%b dado=%h want 1/0", e, d); end
        xact(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, d, e, lat, lat_z);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL err_illegal_size: got erro=%b dado=%h want 1/0", e, d); end
        xact(1'b1, 2'b11, 1'b0, 32'h00, 32'h11111111, d, e, lat, lat_z);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL err_illegal_store: got erro=%b want 1", e); end
        xact(1'b1, 2'b10, 1'b0, 32'h100, 32'h5A5A5A5A, d, e, lat, lat_z);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL err_out_of_range: got erro=%b dado=%h want 1/0", e, d); end
        xact(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, d, e, lat, lat_z);
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL err_last_word: got erro=%b want 0", e); end
        xact(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, d, e, lat, lat_z);
        checks++; if (d !== 32'hCAFEF00D || e !== 1'b0) begin failures++; $display("FAIL err_word0_kept: got %h want cafef00d", d); end
        xact(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, d, e, lat, lat_z);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL err_word1_kept: got %h want 0", d); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic e; int lat, lat_z;
        @(negedge clk);
        req_escreve = 1'b0; req_tamanho = 2'b10; req_sem_sinal = 1'b0;
        req_endereco = 32'h08; req_dado = 32'h0; req_valido = 1'b1;
        @(posedge clk);
        #1;
        req_valido = 1'b0;
        @(negedge clk);
        checks++; if (req_pronto !== 1'b0) begin failures++; $display("FAIL bp_pronto_espera: got %b want 0", req_pronto); end
        for (int n = 0; n < 10 && !resp_valido; n++) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            req_escreve = 1'b1; req_endereco = 32'h08; req_dado = 32'h0; req_valido = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (resp_valido !== 1'b1 || resp_dado !== 32'hDEADBEEF || resp_erro !== 1'b0 || req_pronto !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d: got valido=%b dado=%h erro=%b pronto=%b want 1/deadbeef/0/0",
                         c, resp_valido, resp_dado, resp_erro, req_pronto);
            end
        end
        req_valido  = 1'b0;
        resp_aceito = 1'b1;
        @(posedge clk);
        #1;
        resp_aceito = 1'b0;
        checks++;
        if (resp_valido !== 1'b0 || resp_dado !== 32'h0 || req_pronto !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: got valido=%b dado=%h pronto=%b want 0/0/1", resp_valido, resp_dado, req_pronto);
        end
        xact(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, d, e, lat, lat_z);
        checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL bp_ignored_store: got %h want deadbeef", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e; int lat, lat_z;
        xact(1'b1, 2'b10, 1'b0, 32'h04, 32'h12345678, d, e, lat, lat_z);
        @(negedge clk);
        req_escreve = 1'b1; req_tamanho = 2'b10; req_sem_sinal = 1'b0;
        req_endereco = 32'h04; req_dado = 32'hFFFFFFFF; req_valido = 1'b1;
        @(posedge clk);
        #1;
        req_valido = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (req_pronto !== 1'b0 || resp_valido !== 1'b0 || resp_valido_z !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: got pronto=%b valido=%b valido_z=%b want 0/0/1", req_pronto, resp_valido, resp_valido_z);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_pronto !== 1'b1 || resp_valido !== 1'b0 || resp_dado !== 32'h0 || resp_erro !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_outputs: got pronto=%b valido=%b dado=%h erro=%b want 1/0/0/0",
                     req_pronto, resp_valido, resp_dado, resp_erro);
        end
        checks++; if (resp_valido_z !== 1'b0) begin failures++; $display("FAIL rstmid_resposta_lost: got %b want 0", resp_valido_z); end
        @(negedge clk);
        rst = 1'b1;
        xact(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, d, e, lat, lat_z);
        checks++; if (d !== 32'h12345678) begin failures++; $display("FAIL rstmid_no_write: got %h want 12345678", d); end
    endtask

    initial begin
        rst = 1'b0;
        req_valido = 1'b0; req_escreve = 1'b0; req_tamanho = 2'b00; req_sem_sinal = 1'b0;
        req_endereco = 32'h0; req_dado = 32'h0; resp_aceito = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        test_word();
        test_half();
        test_byte();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
